// File: rtl/branch_annul_controller.sv
// branch_annul_controller: holds the pipeline after reset, then picks the PC source per branch and annuls delay slots.
module branch_annul_controller #(
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 system_reset_n,
  input  logic                 ID_branch_instr,
  input  logic                 ID_branch_always,
  input  logic                 a,
  input  logic                 cond_true,
  input  logic                 hazard_stall,
  output logic [1:0]           pc_src,
  output logic                 pipe_enable,
  output logic                 IF_ID_reset,
  output logic                 ID_EX_reset,
  output logic                 boot_done,
  output logic [CNT_WIDTH-1:0] annul_count
);
  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, ANNUL = 2'd2} state_t;
  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);
  state_t state, next_state;
  logic [3:0] hold_cnt;
  logic annul_evt;
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      annul_count <= '0;
      boot_done   <= 1'b0;
    end else begin
      state       <= next_state;
      hold_cnt    <= (state == HOLD) ? hold_cnt + 4'd1 : hold_cnt;
      annul_count <= annul_evt ? annul_count + CNT_WIDTH'(1) : annul_count;
      boot_done   <= boot_done | (state == HOLD && next_state == RUN);
    end
  end
  always_comb begin
    next_state  = state;
    pc_src      = 2'b00;
    pipe_enable = 1'b1;
    IF_ID_reset = 1'b0;
    ID_EX_reset = 1'b0;
    annul_evt   = 1'b0;
    case (state)
      HOLD: begin
        pc_src      = 2'b10;
        IF_ID_reset = 1'b1;
        ID_EX_reset = 1'b1;
        next_state  = (hold_cnt == HOLD_LAST) ? RUN : HOLD;
      end
      RUN: begin
        if (hazard_stall) begin
          pipe_enable = 1'b0;
          ID_EX_reset = 1'b1;
        end else if (ID_branch_instr) begin
          pc_src      = (cond_true | ID_branch_always) ? 2'b01 : 2'b00;
          annul_evt   = a & (~cond_true | ID_branch_always);
          IF_ID_reset = annul_evt;
          next_state  = annul_evt ? ANNUL : RUN;
        end
      end
      ANNUL: begin
        pipe_enable = ~hazard_stall;
        ID_EX_reset = hazard_stall;
        next_state  = hazard_stall ? ANNUL : RUN;
      end
      default: begin
        pc_src      = 2'b10;
        IF_ID_reset = 1'b1;
        ID_EX_reset = 1'b1;
        next_state  = HOLD;
      end
    endcase
  end
endmodule

// File: tb/tb_branch_annul_controller.sv
// tb_branch_annul_controller: directed checks of hold, branch, annul, stall and counter wrap.
module tb_branch_annul_controller;
  logic clk = 1'b0;
  logic system_reset_n, br, ba, a, ct, st;
  logic [1:0] pc_src, pc_src2;
  logic pipe_enable, IF_ID_reset, ID_EX_reset, boot_done;
  logic pe2, ifr2, exr2, bd2;
  logic [15:0] annul_count;
  logic [1:0] cnt2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_annul_controller dut (
    .clk(clk), .system_reset_n(system_reset_n), .ID_branch_instr(br),
    .ID_branch_always(ba), .a(a), .cond_true(ct), .hazard_stall(st),
    .pc_src(pc_src), .pipe_enable(pipe_enable), .IF_ID_reset(IF_ID_reset),
    .ID_EX_reset(ID_EX_reset), .boot_done(boot_done), .annul_count(annul_count)
  );

  branch_annul_controller #(.RESET_HOLD_CYCLES(4), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .system_reset_n(system_reset_n), .ID_branch_instr(br),
    .ID_branch_always(ba), .a(a), .cond_true(ct), .hazard_stall(st),
    .pc_src(pc_src2), .pipe_enable(pe2), .IF_ID_reset(ifr2),
    .ID_EX_reset(exr2), .boot_done(bd2), .annul_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic b, input logic f, input logic an, input logic c, input logic s);
    br = b; ba = f; a = an; ct = c; st = s;
    #1;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_pc"}, 32'(pc_src), 2);
    chk({tag, "_pe"}, 32'(pipe_enable), 1);
    chk({tag, "_ifr"}, 32'(IF_ID_reset), 1);
    chk({tag, "_exr"}, 32'(ID_EX_reset), 1);
    chk({tag, "_boot"}, 32'(boot_done), 0);
  endtask

  initial begin
    system_reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2;
    chk_hold("rst");
    chk("rst_cnt", 32'(annul_count), 0);
    @(negedge clk);
    system_reset_n = 1'b1;
    drive(1, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk_hold($sformatf("hold%0d", i));
      cyc();
    end
    drive(0, 0, 0, 0, 0);
    chk("run_boot", 32'(boot_done), 1);
    chk("run_pc", 32'(pc_src), 0);
    chk("run_ifr", 32'(IF_ID_reset), 0);
    chk("run_exr", 32'(ID_EX_reset), 0);
    // taken, not annulled
    drive(1, 0, 0, 1, 0);
    chk("tk_pc", 32'(pc_src), 1);
    chk("tk_ifr", 32'(IF_ID_reset), 0);
    cyc();
    drive(1, 0, 0, 1, 0);
    chk("tk_still_run_pc", 32'(pc_src), 1);
    chk("tk_cnt", 32'(annul_count), 0);
    // untaken with annul bit
    drive(1, 0, 1, 0, 0);
    chk("nt_pc", 32'(pc_src), 0);
    chk("nt_ifr", 32'(IF_ID_reset), 1);
    cyc();
    chk("nt_cnt", 32'(annul_count), 1);
    chk("nt_cnt2", 32'(cnt2), 1);
    drive(1, 0, 0, 1, 0);
    chk("annul_mask_pc", 32'(pc_src), 0);
    chk("annul_mask_ifr", 32'(IF_ID_reset), 0);
    chk("annul_pe", 32'(pipe_enable), 1);
    cyc();
    // BA with annul bit
    drive(1, 1, 1, 1, 0);
    chk("ba_pc", 32'(pc_src), 1);
    chk("ba_ifr", 32'(IF_ID_reset), 1);
    cyc();
    chk("ba_cnt", 32'(annul_count), 2);
    chk("ba_cnt2", 32'(cnt2), 2);
    drive(0, 0, 0, 0, 0);
    cyc();
    // stall overrides an annulling branch for two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0, 1);
      chk($sformatf("stall%0d_pe", i), 32'(pipe_enable), 0);
      chk($sformatf("stall%0d_exr", i), 32'(ID_EX_reset), 1);
      chk($sformatf("stall%0d_ifr", i), 32'(IF_ID_reset), 0);
      chk($sformatf("stall%0d_pc", i), 32'(pc_src), 0);
      cyc();
      chk($sformatf("stall%0d_cnt", i), 32'(annul_count), 2);
    end
    drive(1, 0, 1, 0, 0);
    chk("unstall_ifr", 32'(IF_ID_reset), 1);
    chk("unstall_pe", 32'(pipe_enable), 1);
    chk("unstall_exr", 32'(ID_EX_reset), 0);
    cyc();
    chk("unstall_cnt", 32'(annul_count), 3);
    chk("unstall_cnt2", 32'(cnt2), 3);
    // stall while in ANNUL keeps ANNUL
    drive(0, 0, 0, 0, 1);
    chk("annul_stall_pe", 32'(pipe_enable), 0);
    chk("annul_stall_exr", 32'(ID_EX_reset), 1);
    cyc();
    drive(1, 0, 0, 1, 0);
    chk("annul_held_pc", 32'(pc_src), 0);
    cyc();
    drive(1, 0, 0, 1, 0);
    chk("back_run_pc", 32'(pc_src), 1);
    chk("back_run_cnt", 32'(annul_count), 3);
    // two more annuls wrap the 2-bit counter
    drive(1, 0, 1, 0, 0);
    cyc();
    chk("wrap_cnt", 32'(annul_count), 4);
    chk("wrap_cnt2", 32'(cnt2), 0);
    drive(0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 1, 0, 0);
    cyc();
    chk("wrap2_cnt", 32'(annul_count), 5);
    chk("wrap2_cnt2", 32'(cnt2), 1);
    // reset mid-ANNUL takes effect without a clock edge
    drive(1, 0, 1, 0, 0);
    system_reset_n = 1'b0;
    #1;
    chk_hold("midrst");
    chk("midrst_cnt", 32'(annul_count), 0);
    chk("midrst_cnt2", 32'(cnt2), 0);
    chk("midrst_bd2", 32'(bd2), 0);
    cyc();
    chk("midrst_held_pc", 32'(pc_src), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_annul_controller.md
Name: branch_annul_controller

Overview:
- Sequences pipeline control around the reset/annul path of the SPARC pipeline.
- Holds the front end in reset for a fixed number of cycles after system reset, then selects the PC source for each branch resolved in ID.
- Drives the IF/ID reset that annuls a delay slot and the ID/EX bubble insert.
- Arbitrates simultaneous hazard stalls and branch decisions, and counts annulled delay slots.

Parameters:
- RESET_HOLD_CYCLES, 4: cycles the pipeline is held after system_reset_n deasserts. Legal range is 1..15.
- CNT_WIDTH, 16: width of the annul event counter.

Ports:
- clk, input, 1: pipeline clock; all state updates on the rising edge.
- system_reset_n, input, 1: asynchronous, active-low system reset.
- ID_branch_instr, input, 1: a branch is present in the ID stage.
- ID_branch_always, input, 1: the branch in ID is unconditional (BA).
- a, input, 1: annul bit of the branch in ID.
- cond_true, input, 1: condition evaluation result for the branch in ID.
- hazard_stall, input, 1: stall request from the hazard unit.
- pc_src, output, 2: PC mux select. 00 = nPC sequential, 01 = branch target, 10 = reset vector.
- pipe_enable, output, 1: PC/nPC and IF/ID load enable.
- IF_ID_reset, output, 1: clears the IF/ID register at the next edge (annul or hold).
- ID_EX_reset, output, 1: inserts a bubble into ID/EX at the next edge.
- boot_done, output, 1: high once the controller leaves HOLD.
- annul_count, output, CNT_WIDTH: number of delay slots annulled since reset; wraps.

Behaviour:
- States are HOLD, RUN and ANNUL, in a 2-bit state register.
- Asynchronous reset (system_reset_n = 0), taking effect immediately regardless of clk:
  - state = HOLD, hold counter = 0, annul_count = 0, boot_done = 0.
  - Outputs: pc_src = 10, pipe_enable = 1, IF_ID_reset = 1, ID_EX_reset = 1.
- HOLD:
  - Outputs as in reset, so the PC reloads the reset vector every cycle.
  - Hold counter increments each edge.
  - When counter == RESET_HOLD_CYCLES-1, next state = RUN.
  - Branch and stall inputs are ignored.
- RUN (outputs are combinational on the current inputs):
  - Defaults: pc_src = 00, pipe_enable = 1, IF_ID_reset = 0, ID_EX_reset = 0.
  - If hazard_stall = 1, the stall has priority:
    - pipe_enable = 0, ID_EX_reset = 1, pc_src = 00, IF_ID_reset = 0.
    - The branch in ID is not resolved this cycle; it is re-evaluated when the stall drops.
  - Else if ID_branch_instr = 1:
    - taken = cond_true | ID_branch_always.
    - pc_src = 01 if taken, else 00.
    - annul = a & (~cond_true | ID_branch_always), i.e. annul when a=1 and the branch is not taken, or when a=1 and the branch is BA.
    - If annul: IF_ID_reset = 1, next state = ANNUL, and annul_count increments at that edge.
  - Otherwise the defaults apply.
- ANNUL (one cycle only; the annulled slot bubble is in ID):
  - ID_branch_instr is masked (treated as 0), pc_src = 00, pipe_enable = 1.
  - If hazard_stall = 1: stay in ANNUL with pipe_enable = 0 and ID_EX_reset = 1.
  - Otherwise next state = RUN.
- boot_done:
  - Registered; set at the HOLD->RUN edge and stays 1 until reset.
- annul_count:
  - Wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- Delay-slot branch: a non-annulled branch followed by a branch in its delay slot is handled normally in RUN; no special casing.
- Reset asserted mid-ANNUL or mid-stall: forces HOLD immediately; the pending annul is discarded and the count is not incremented.
- Illegal state encoding: next state = HOLD.

Test Plan:
- Reset then release with RESET_HOLD_CYCLES=4 -> pc_src=10, IF_ID_reset=1, ID_EX_reset=1 for exactly 4 edges after release; boot_done=1 and pc_src=00 from the 5th cycle.
- RUN, ID_branch_instr=1, cond_true=1, a=0, ID_branch_always=0 -> pc_src=01, IF_ID_reset=0, state stays RUN, annul_count=0.
- RUN, ID_branch_instr=1, cond_true=0, a=1 -> pc_src=00, IF_ID_reset=1, ANNUL for one cycle, annul_count=1. Repeat with ID_branch_always=1, cond_true=1, a=1 -> pc_src=01, IF_ID_reset=1, annul_count=2.
- RUN, hazard_stall=1 with ID_branch_instr=1, a=1, cond_true=0 for 2 cycles -> pipe_enable=0, ID_EX_reset=1, IF_ID_reset=0, count unchanged; on stall release the branch resolves with IF_ID_reset=1 and annul_count increments by 1.
- In ANNUL, drive ID_branch_instr=1, cond_true=1 -> pc_src stays 00 (masked); next cycle returns to RUN.
- CNT_WIDTH=2, perform 5 annuls -> annul_count sequence 1,2,3,0,1. Assert system_reset_n=0 mid-ANNUL -> immediate HOLD outputs, annul_count=0, boot_done=0.
